// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and helpers for the MEM-stage load/store sequencer
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} mau_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  function automatic logic [3:0] size_mask(size_t sz);
    logic [3:0] m;
    case (sz)
      SZ_B:    m = 4'b0001;
      SZ_H:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] size_bytes(size_t sz);
    logic [2:0] n;
    case (sz)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // BU/HU encodings only mean "unsigned narrow" for loads; a store with them is a word
  function automatic size_t decode_size(logic [2:0] f3, logic is_load);
    size_t sz;
    if (f3 == F3_B || (is_load && f3 == F3_BU))      sz = SZ_B;
    else if (f3 == F3_H || (is_load && f3 == F3_HU)) sz = SZ_H;
    else                                             sz = SZ_W;
    return sz;
  endfunction

endpackage

// File: rtl/ls_lane_align.sv
// rtl/ls_lane_align.sv - byte-lane strobe/data shifting for stores and extract/extend for loads
module ls_lane_align
  import mem_access_pkg::*;
(
  input  size_t       size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [3:0]  wr_lo,
  output logic [3:0]  wr_hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] load_data
);

  logic [7:0]  mask_sh;
  logic [5:0]  hi_shift;
  logic [31:0] rd_sh;

  always_comb begin
    mask_sh   = {4'b0000, size_mask(size)} << offset;
    wr_lo     = mask_sh[3:0];
    wr_hi     = mask_sh[7:4];
    wdata_lo  = wdata << {offset, 3'b000};
    // offset 0 never splits; the 32-bit shift then simply yields zero
    hi_shift  = 6'd32 - {1'b0, offset, 3'b000};
    wdata_hi  = wdata >> hi_shift;
    rd_sh     = 32'({hi_word, lo_word} >> {offset, 3'b000});
    case (size)
      SZ_B:    load_data = {{24{sign_ext & rd_sh[7]}}, rd_sh[7:0]};
      SZ_H:    load_data = {{16{sign_ext & rd_sh[15]}}, rd_sh[15:0]};
      default: load_data = rd_sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store sequencer with word-boundary splitting
// Optional MISALIGN_TRAP_EN: split accesses fault instead of issuing a second access.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_load,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [3:0]            mem_wr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_fault,
  output logic                  stall
);

  localparam int WA = DM_ADDRESS - 2;

  mau_state_t state, state_nx;

  logic              is_load;
  size_t             size;
  logic              sign_ext;
  logic [1:0]        offset;
  logic [WA-1:0]     word;
  logic [WA-1:0]     word_hi;
  logic [31:0]       wdata;
  logic              split;
  logic [31:0]       lo_buf, hi_buf, rsp_hold;

  logic              accept;
  size_t             req_size;
  logic [2:0]        req_end;
  logic              fault_now;
  logic [3:0]        wr_lo, wr_hi;
  logic [31:0]       wdata_lo, wdata_hi, load_data, rsp_now;
  logic              unused_addr;

  assign unused_addr = ^req_addr[31:DM_ADDRESS];
  assign accept      = (state == IDLE) & req_valid & (req_load | req_store);
  assign req_size    = decode_size(req_funct3, req_load);
  assign req_end     = {1'b0, req_addr[1:0]} + size_bytes(req_size);
  assign word_hi     = word + WA'(1);

`ifdef MISALIGN_TRAP_EN
  assign fault_now = split;
`else
  assign fault_now = 1'b0;
`endif

  assign rsp_now = (is_load && !fault_now) ? load_data : 32'h0;

  ls_lane_align u_align (
    .size      (size),
    .sign_ext  (sign_ext),
    .offset    (offset),
    .wdata     (wdata),
    .lo_word   (lo_buf),
    .hi_word   (hi_buf),
    .wr_lo     (wr_lo),
    .wr_hi     (wr_hi),
    .wdata_lo  (wdata_lo),
    .wdata_hi  (wdata_hi),
    .load_data (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ACC0;
      ACC0:    state_nx = (split && !fault_now) ? ACC1 : RESP;
      ACC1:    state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_load  <= 1'b0;
      size     <= SZ_B;
      sign_ext <= 1'b0;
      offset   <= 2'b00;
      word     <= '0;
      wdata    <= '0;
      split    <= 1'b0;
      lo_buf   <= '0;
      hi_buf   <= '0;
      rsp_hold <= '0;
    end else begin
      if (accept) begin
        is_load  <= req_load;
        size     <= req_size;
        sign_ext <= req_load & (req_funct3 == F3_B || req_funct3 == F3_H);
        offset   <= req_addr[1:0];
        word     <= req_addr[DM_ADDRESS-1:2];
        wdata    <= req_wdata;
        split    <= req_end > 3'd4;
      end
      if (state == ACC0 && is_load) lo_buf <= mem_rdata;
      if (state == ACC1 && is_load) hi_buf <= mem_rdata;
      if (state == RESP)            rsp_hold <= rsp_now;
    end
  end

  always_comb begin
    req_ready = 1'b0;
    mem_addr  = '0;
    mem_wr    = 4'b0000;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    rsp_data  = rsp_hold;
    rsp_fault = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      ACC0: begin
        mem_addr = {word, 2'b00};
        if (!is_load && !fault_now) begin
          mem_wr    = wr_lo;
          mem_wdata = wdata_lo;
        end
      end
      ACC1: begin
        mem_addr = {word_hi, 2'b00};
        if (!is_load) begin
          mem_wr    = wr_hi;
          mem_wdata = wdata_hi;
        end
      end
      default: begin
        rsp_valid = 1'b1;
        rsp_data  = rsp_now;
        rsp_fault = fault_now;
      end
    endcase
  end

  assign stall = ~req_ready;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a byte-array reference model
// Honours MISALIGN_TRAP_EN when the design is built with it.
module tb_mem_access_unit;

  localparam int DM = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_load = 1'b0;
  logic          req_store = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic [DM-1:0] mem_addr;
  logic [3:0]    mem_wr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          rsp_fault;
  logic          stall;

  always #5 clk = ~clk;

  mem_access_unit #(.DM_ADDRESS(DM), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_load   (req_load),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_fault  (rsp_fault),
    .stall      (stall)
  );

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  dm[512];
  logic [7:0]  ref_mem[512];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_exp;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 4; i++) mem_rdata[8*i +: 8] = dm[{mem_addr[8:2], 2'(i)}];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic poke_word(input int a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      dm[a + i]      = v[8*i +: 8];
      ref_mem[a + i] = v[8*i +: 8];
    end
  endtask

  // Reference: byte-addressed memory, little-endian, addresses wrap mod 512
  task automatic model(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] d, output logic f,
                       output int lat);
    int          nb;
    int          a;
    logic        sgn;
    logic        spl;
    logic [63:0] m;
    if (ld) nb = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    else    nb = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    sgn = ld && (f3 == 3'd0 || f3 == 3'd1);
    a   = int'(addr[8:0]);
    spl = (int'(addr[1:0]) + nb) > 4;
    d   = 32'h0;
    f   = 1'b0;
    lat = spl ? 3 : 2;
`ifdef MISALIGN_TRAP_EN
    if (spl) begin
      f   = 1'b1;
      lat = 2;
      return;
    end
`endif
    if (ld) begin
      for (int i = 0; i < nb; i++) d = d | (32'(ref_mem[(a + i) % 512]) << (8 * i));
      m = (64'd1 << (8 * nb)) - 64'd1;
      if (sgn && d[8*nb-1]) d = d | ~m[31:0];
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[(a + i) % 512] = wd[8*i +: 8];
    end
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input bit push);
    int          n;
    logic [31:0] d;
    logic        f;
    int          lat;
    @(negedge clk);
    req_valid  = 1'b1;
    req_load   = ld;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {31'b0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    if (push) begin
      model(ld, f3, addr, wd, d, f, lat);
      sb.push_back('{d, f, lat, cyc});
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    req_load  = 1'b0;
    req_store = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    int         n;
    for (int i = 0; i < 512; i++) begin
      b = 8'($urandom);
      dm[i] = b;
      ref_mem[i] = b;
    end
    last_exp = 32'h0;

    fork
      forever begin
        @(posedge clk);
        for (int i = 0; i < 4; i++)
          if (mem_wr[i]) dm[{mem_addr[8:2], 2'(i)}] <= mem_wdata[8*i +: 8];
      end
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          last_exp = 32'h0;
        end else begin
          chk("stall", {31'b0, stall}, {31'b0, ~req_ready});
          if (rsp_valid) begin
            if (sb.size() == 0) begin
              chk("unexpected_rsp", {31'b0, rsp_valid}, 32'h0);
            end else begin
              exp_t e;
              e = sb.pop_front();
              chk("rsp_data", rsp_data, e.data);
              chk("rsp_fault", {31'b0, rsp_fault}, {31'b0, e.fault});
              chk("rsp_latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
              last_exp = e.data;
            end
          end else begin
            chk("rsp_data_hold", rsp_data, last_exp);
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_fault", {31'b0, rsp_fault}, 32'h0);
    chk("rst_mem_wr", {28'b0, mem_wr}, 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    rst_n = 1'b1;

    issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1);
    @(negedge clk);
    chk("sw_acc0_addr", 32'(mem_addr), 32'h10);
    chk("sw_acc0_wr", {28'b0, mem_wr}, 32'hF);
    chk("sw_acc0_wdata", mem_wdata, 32'hDEADBEEF);
    idle(2);

    poke_word(32'h10, 32'h80123456);
    issue(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 1);
    issue(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 1);
    idle(2);

    issue(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000ABCD, 1);
    @(negedge clk);
    chk("sh_acc0_addr", 32'(mem_addr), 32'h10);
    chk("sh_acc0_wr", {28'b0, mem_wr}, 32'hC);
    chk("sh_acc0_wdata", mem_wdata, 32'hABCD0000);
    @(negedge clk);
    chk("sh_single_access", {28'b0, mem_wr}, 32'h0);
    idle(2);

    poke_word(32'h1C, 32'h44332211);
    poke_word(32'h20, 32'h88776655);
    issue(1'b1, 1'b0, 3'b010, 32'h1E, 32'h0, 1);
    @(negedge clk);
    chk("lw_acc0_addr", 32'(mem_addr), 32'h1C);
    chk("lw_acc0_wr", {28'b0, mem_wr}, 32'h0);
    @(negedge clk);
`ifdef MISALIGN_TRAP_EN
    chk("lw_trap_no_acc1", 32'(mem_addr), 32'h0);
`else
    chk("lw_acc1_addr", 32'(mem_addr), 32'h20);
`endif
    idle(2);

    issue(1'b0, 1'b1, 3'b010, 32'h1FF, 32'hAABBCCDD, 1);
    @(negedge clk);
    chk("sw_wrap_acc0_addr", 32'(mem_addr), 32'h1FC);
`ifdef MISALIGN_TRAP_EN
    chk("sw_trap_acc0_wr", {28'b0, mem_wr}, 32'h0);
`else
    chk("sw_wrap_acc0_wr", {28'b0, mem_wr}, 32'h8);
    chk("sw_wrap_acc0_wdata", mem_wdata, 32'hDD000000);
    @(negedge clk);
    chk("sw_wrap_acc1_addr", 32'(mem_addr), 32'h0);
    chk("sw_wrap_acc1_wr", {28'b0, mem_wr}, 32'h7);
    chk("sw_wrap_acc1_wdata", mem_wdata, 32'h00AABBCC);
`endif
    idle(2);

    // Reset in the middle of an access: no response, only completed halves land
`ifdef MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0);
    @(negedge clk);
`else
    issue(1'b0, 1'b1, 3'b010, 32'h1FF, 32'h55667788, 0);
    ref_mem[511] = 8'h88;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_acc1_wr", {28'b0, mem_wr}, 32'h7);
`endif
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_load = 1'b0;
    req_store = 1'b0;
    #1;
    chk("rst_mid_mem_wr", {28'b0, mem_wr}, 32'h0);
    chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", {31'b0, req_ready}, 32'h1);
    idle(2);

    for (int k = 0; k < 150; k++) begin
      int          kind;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] w;
      kind = $urandom_range(0, 9);
      f3   = 3'($urandom);
      a    = $urandom;
      w    = $urandom;
      if (kind == 0) begin
        @(negedge clk);
        req_valid = 1'b1;
        req_load  = 1'b0;
        req_store = 1'b0;
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
      end else if (kind <= 4) begin
        issue(1'b1, 1'b0, f3, a, w, 1);
      end else if (kind <= 8) begin
        issue(1'b0, 1'b1, f3, a, w, 1);
      end else begin
        issue(1'b1, 1'b1, f3, a, w, 1);
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
    end
    idle(1);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    for (int i = 0; i < 512; i++) begin
      if (dm[i] !== ref_mem[i]) chk($sformatf("mem_byte_%0h", i), 32'(dm[i]), 32'(ref_mem[i]));
      else checks++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer that sits directly upstream of datamemory in the MEM stage.
- Accepts one EX-stage memory request at a time and drives the datamemory word address, byte-lane write strobes and lane-shifted write data.
- Captures the returned word, then aligns and sign- or zero-extends it for writeback.
- Accesses that cross a word boundary are split into two word accesses by an internal FSM.

Parameters:
- DM_ADDRESS, 9, byte-address width of data memory; word address = addr[DM_ADDRESS-1:2].
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  EX request present.
- req_ready  out  1  unit idle, request accepted this cycle when req_valid is also high.
- req_load  in  1  request is a load.
- req_store  in  1  request is a store.
- req_funct3  in  3  instruction bits 14:12.
- req_addr  in  32  ALU result byte address; only [DM_ADDRESS-1:0] is used.
- req_wdata  in  32  store data (rs2).
- mem_addr  out  DM_ADDRESS  word-aligned address to datamemory; low 2 bits are always 0.
- mem_wr  out  4  byte-lane write strobes; bit i = byte i (little-endian).
- mem_wdata  out  32  lane-shifted store data.
- mem_rdata  in  32  datamemory read word; valid before the rising edge that ends an access cycle.
- rsp_valid  out  1  one-cycle pulse, response complete.
- rsp_data  out  32  extended load result; 0 for stores.
- rsp_fault  out  1  misaligned trap; present only with MISALIGN_TRAP_EN, otherwise tied 0.
- stall  out  1  equals ~req_ready; used to freeze IF/ID/EX.

Behaviour:
- States: IDLE, ACC0, ACC1, RESP. Async reset forces IDLE.
- Reset values: rsp_valid=0, rsp_data=0, rsp_fault=0, mem_wr=0, mem_addr=0, mem_wdata=0, internal buffers=0.
- IDLE:
  - req_ready=1.
  - On req_valid & (req_load|req_store), latch the request and go to ACC0.
  - req_valid with neither load nor store is ignored.
  - If req_load and req_store are both set, the load wins.
- Size from funct3:
  - 000 = B.
  - 001 = H.
  - 010 = W.
  - 100 = BU, load only.
  - 101 = HU, load only.
  - Any other funct3 is treated as W.
- Offset and split: o = addr[1:0]; split = (o + size_bytes) > 4.
- ACC0:
  - mem_addr = {addr[DM_ADDRESS-1:2], 2'b00}.
  - Store strobes: mem_wr = (size_mask << o)[3:0]; mem_wdata = wdata << 8*o.
  - Load: mem_wr=0; mem_rdata is captured into lo_buf at the end of the cycle.
  - Next state: ACC1 if split, else RESP.
- ACC1:
  - Word address = ACC0 word + 1, wrapping modulo 2^(DM_ADDRESS-2); the last word wraps to word 0.
  - mem_wr = (size_mask << o)[7:4].
  - mem_wdata = wdata >> 8*(4-o).
  - Load: capture hi_buf. Next state: RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_data is valid in the same cycle and holds until the next response.
  - Load: extract size_bytes starting at byte o of {hi_buf, lo_buf}, then sign-extend (B/H) or zero-extend (BU/HU/W).
  - Next state: IDLE.
- Latency from the accept edge: rsp_valid 2 cycles later if aligned, 3 cycles later if split. Throughput is one request per 3 or 4 cycles.
- mem_wr is decoded from state, so it is 0 outside ACC0/ACC1 and drops immediately on reset assertion.
- Reset mid-operation: any completed ACC0 store half stays written; no response is produced; req_ready=1 on the first cycle after release.
- A new req_valid is not accepted in RESP; it is accepted one cycle later in IDLE.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a request with split=1 takes ACC0 with mem_wr=0, then RESP with rsp_fault=1 and rsp_data=0. ACC1 is never entered and memory is never written.
- Undefined: split accesses are performed as above and rsp_fault is constant 0.

Decomposition:
- Package mem_access_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - typedef enum mau_state_t {IDLE, ACC0, ACC1, RESP}.
  - typedef enum size_t {SZ_B, SZ_H, SZ_W}.
  - Function size_mask(size_t) returning 4'b0001 / 4'b0011 / 4'b1111.
- Sub-module ls_lane_align (combinational): store strobe/data shift for both halves and the load extract/extend path. The top level keeps the FSM and buffers.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF -> ACC0: mem_addr=0x10, mem_wr=1111, mem_wdata=0xDEADBEEF; rsp_valid 2 cycles after accept, rsp_data=0.
- LB then LBU at 0x13, word 0x10=0x80123456 -> rsp_data=0xFFFFFF80, then 0x00000080.
- SH addr 0x12, wdata 0x0000ABCD -> mem_wr=1100, mem_wdata=0xABCD0000, single access.
- LW addr 0x1E, word 0x1C=0x44332211, word 0x20=0x88776655 -> two access cycles (0x1C, 0x20), rsp_data=0x66554433 3 cycles after accept. With MISALIGN_TRAP_EN: rsp_fault=1, rsp_data=0, no access to 0x20.
- SW addr 0x1FF, wdata 0xAABBCCDD (DM_ADDRESS=9) -> ACC0: 0x1FC, wr=1000, wdata=0xDD000000; ACC1: 0x000, wr=0111, wdata=0x00AABBCC.
- rst_n low during ACC1 of the 0x1FF store -> mem_wr=0 immediately, rsp_valid never pulses, byte 0x1FF=0xDD retained, req_ready=1 after release.
